// File: rtl/post_scheduler.sv
// Post-processing sequencer for one MAC tile: fetches each channel's K/B/bias
// entry, then streams that channel's serializer rows through the channel mux.
module post_scheduler #(
    parameter int CHANNEL_N = 2,
    parameter int POY       = 3,
    parameter int OCH_MAX   = 64,
    parameter int ADDR_W    = $clog2(OCH_MAX)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mac_output_valid,
    input  logic [ADDR_W-1:0]            cfg_och_base,
    input  logic                         post_ready,
    output logic                         busy,
    output logic [$clog2(CHANNEL_N)-1:0] mux_sel,
    output logic [$clog2(POY)-1:0]       row_idx,
    output logic                         post_valid,
    output logic                         param_rd_en,
    output logic [ADDR_W-1:0]            param_rd_addr,
    output logic                         tile_done,
    output logic                         err_overrun,
    output logic [1:0]                   state_dbg
);

    localparam int SEL_W = $clog2(CHANNEL_N);
    localparam int ROW_W = $clog2(POY);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(POY - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNEL_N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [SEL_W-1:0]   ch;
    logic [ROW_W-1:0]   row;
    logic               start_ok;
    logic               beat_done;

    // Handshake: a beat transfers on a rising edge where post_valid && post_ready;
    // while post_ready is low the beat (mux_sel, row_idx, post_valid) holds unchanged.
    assign start_ok  = mac_output_valid && ((state == IDLE) || (state == DONE));
    assign beat_done = post_valid && post_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            base          <= '0;
            ch            <= '0;
            row           <= '0;
            busy          <= 1'b0;
            mux_sel       <= '0;
            row_idx       <= '0;
            post_valid    <= 1'b0;
            param_rd_en   <= 1'b0;
            param_rd_addr <= '0;
            tile_done     <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            tile_done   <= 1'b0;
            param_rd_en <= 1'b0;
            // A start pulse mid-tile is dropped but remembered until reset.
            if (mac_output_valid && ((state == FETCH) || (state == STREAM)))
                err_overrun <= 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state         <= FETCH;
                        base          <= cfg_och_base;
                        ch            <= '0;
                        row           <= '0;
                        busy          <= 1'b1;
                        param_rd_en   <= 1'b1;
                        param_rd_addr <= cfg_och_base;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FETCH: begin
                    state      <= STREAM;
                    post_valid <= 1'b1;
                    mux_sel    <= ch;
                    row_idx    <= row;
                end
                STREAM: begin
                    if (beat_done) begin
                        if (row != ROW_LAST) begin
                            row     <= row + 1'b1;
                            row_idx <= row + 1'b1;
                        end else if (ch != CH_LAST) begin
                            state         <= FETCH;
                            row           <= '0;
                            ch            <= ch + 1'b1;
                            post_valid    <= 1'b0;
                            param_rd_en   <= 1'b1;
                            param_rd_addr <= base + ADDR_W'(ch) + 1'b1;
                        end else begin
                            state      <= DONE;
                            post_valid <= 1'b0;
                            busy       <= 1'b0;
                            tile_done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/post_scheduler.md
Name: post_scheduler

Overview:
- Sequences the post-processing path for one MAC tile: walks every output channel and every row of that channel's serializer through the channel mux.
- Fetches the per-channel K/B/bias entry from the parameter buffer before each channel's rows.
- Applies downstream backpressure and flags MAC results that arrive too early.
- Sits between the MAC array, the serializer/mux bank and the post-processing unit, and owns mux_sel and the row index.

Parameters:
- CHANNEL_N, 2, output channels per tile (>=2)
- POY, 3, rows per channel serializer (>=2)
- OCH_MAX, 64, depth of K/B/bias parameter buffer (power of two)
- ADDR_W, $clog2(OCH_MAX), parameter buffer address width

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- mac_output_valid  input  1  one-cycle pulse: MAC tile result ready
- cfg_och_base  input  ADDR_W  output-channel index of the tile's channel 0; sampled on accepted start
- post_ready  input  1  post-processing accepts current beat
- busy  output  1  tile in progress (FETCH/STREAM)
- mux_sel  output  $clog2(CHANNEL_N)  channel currently selected
- row_idx  output  $clog2(POY)  serializer row of current beat
- post_valid  output  1  beat valid toward post-processing
- param_rd_en  output  1  parameter buffer read strobe
- param_rd_addr  output  ADDR_W  parameter buffer address
- tile_done  output  1  one-cycle pulse after last beat accepted
- err_overrun  output  1  sticky: start pulse arrived while busy

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; channel/row counters 0; latched base 0; err_overrun cleared. Reset asserted mid-tile abandons the tile immediately with no tile_done.
- States: IDLE, FETCH, STREAM, DONE.
- Start acceptance:
  - mac_output_valid is accepted in IDLE or DONE.
  - On acceptance: latch cfg_och_base, set ch=0 and row=0, go to FETCH.
  - In DONE with a start: tile_done still pulses that cycle and the next state is FETCH (back-to-back tiles).
- FETCH (exactly 1 cycle): param_rd_en=1, param_rd_addr=(base+ch) mod OCH_MAX (ADDR_W wrap), busy=1, post_valid=0. Next state is STREAM. The parameter buffer has 1-cycle read latency, so its data is valid during the first STREAM cycle.
- STREAM:
  - Outputs: post_valid=1, mux_sel=ch, row_idx=row, busy=1.
  - A beat completes on post_valid&&post_ready. When post_ready is low, all outputs hold and counters freeze.
  - On a completed beat with row<POY-1: row+1.
  - On a completed beat with row==POY-1 and ch<CHANNEL_N-1: row=0, ch+1, go to FETCH.
  - On a completed beat with row==POY-1 and ch==CHANNEL_N-1: go to DONE.
- DONE (1 cycle): tile_done=1, busy=0, post_valid=0. Next state is IDLE unless a start is accepted.
- mux_sel and row_idx are registered and hold their last value outside STREAM. They are reset to 0.
- Overrun: mac_output_valid in FETCH or STREAM is ignored (tile continues unchanged) and sets err_overrun. err_overrun is cleared only by reset.
- Minimum tile duration with post_ready=1: CHANNEL_N*(1+POY)+1 cycles, i.e. 9 cycles at the defaults. The start cycle is T, FETCH is T+1, and DONE is T+9.
- Beats per tile: exactly CHANNEL_N*POY, in order ch-major, row-minor.

Test Plan:
- Defaults, base=5, post_ready=1, pulse at T -> FETCH addr 5 at T+1; beats (0,0),(0,1),(0,2) T+2..T+4; FETCH addr 6 at T+5; beats (1,0..2) T+6..T+8; tile_done at T+9; 6 beats total.
- Same, post_ready low for 3 cycles during beat (1,1) -> mux_sel=1/row_idx=1/post_valid held for 3 cycles; tile_done delayed to T+12; no beat duplicated or dropped.
- base=63, OCH_MAX=64 -> param_rd_addr 63 then 0.
- Second pulse at T+4 -> err_overrun=1 from T+5 and stays high; tile completes normally at T+9; no second tile starts.
- Second pulse exactly at T+9 (DONE) -> tile_done=1 at T+9, FETCH at T+10, second tile completes at T+18.
- rst low at T+6 -> all outputs 0 immediately (asynchronous); after release, IDLE with no tile_done; a new pulse runs a full 9-cycle tile.
